multi_arc_renderer: RTL and testbench
=====================================

// Module: multi_arc_renderer
// PURPOSE
//  Parametrised successor to the fixed three-circle shape FSM. Draws up to N_CIRCLES
//  midpoint (Bresenham) circles back-to-back onto the VGA framebuffer adapter.
//  Adds per-circle enable, per-circle colour and screen clipping. Sits between the
//  task top-level and the vga_adapter plot port (vga_x/vga_y/vga_colour/vga_plot).
// PARAMETERS
//  N_CIRCLES  3    number of circle slots (1..8)
//  X_W        8    x coordinate width
//  Y_W        7    y coordinate width
//  COL_W      3    colour width
//  SCREEN_W   160  pixels with x >= SCREEN_W are clipped
//  SCREEN_H   120  pixels with y >= SCREEN_H are clipped
// PORTS
//  clk         in   1              system clock
//  rst         in   1              asynchronous reset, active-high
//  start       in   1              level request; sampled in IDLE
//  enable      in   N_CIRCLES      per-slot draw enable
//  centre_x    in   N_CIRCLES*X_W  packed slot centres x (slot 0 in LSBs)
//  centre_y    in   N_CIRCLES*Y_W  packed slot centres y
//  radius      in   N_CIRCLES*X_W  packed slot radii
//  colour      in   N_CIRCLES*COL_W packed slot colours
//  octant_mask in   N_CIRCLES*8    per-slot octant enables (ARC_MASK_EN only)
//  done        out  1              high in DONE until start drops
//  vga_x       out  X_W            pixel x
//  vga_y       out  Y_W            pixel y
//  vga_colour  out  COL_W          pixel colour
//  vga_plot    out  1              write strobe, one pixel per cycle
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, slot index 0; reset mid-draw aborts at once.
//  FSM: IDLE -(start)-> LOAD -> INIT -> DRAW -> NEXT -> (INIT | DONE); DONE -(!start)-> IDLE.
//  LOAD (1 cycle): latch all slot inputs into shadow regs; later input changes ignored.
//  INIT (1 cycle): ox=0, oy=r, crit=1-r for current slot; disabled slot goes to NEXT.
//  DRAW: each iteration emits 8 pixels, one per cycle, octants 0..7 in order:
//   (+ox,+oy)(+oy,+ox)(-ox,+oy)(-oy,+ox)(-ox,-oy)(-oy,-ox)(+ox,-oy)(+oy,-ox).
//  After octant 7: ox++; crit<=0 ? crit+=2*ox+1 : (oy--, crit+=2*(ox-oy)+1);
//   continue while oy>=ox, else NEXT. r=0 -> 8 plots at centre. r=1 -> 16 plot cycles.
//  Arithmetic: signed X_W+2 bits; pixel = centre +/- offset computed signed.
//  Clip: negative or >= SCREEN_W/H -> vga_plot=0 that cycle, cycle still consumed.
//  NEXT: slot++; after slot N_CIRCLES-1 -> DONE. vga_plot=0 in all non-DRAW states.
//  vga_x/y/colour hold last value outside DRAW. start dropped mid-draw is ignored.
//  done high only in DONE; start held after done keeps DONE (no redraw).
//  First pixel appears 3 cycles after start sampled (LOAD, INIT, DRAW).
// CONFIGURATION
//  MULTI_ARC_ARC_MASK_EN defined: octant k plotted only if octant_mask[slot*8+k];
//   masked octants suppress vga_plot but keep cycle timing (Reuleaux arcs via masks).
//  Undefined: octant_mask port present but ignored; all 8 octants plotted.
// STRUCTURE
//  renderer_pkg: state_t enum (IDLE,LOAD,INIT,DRAW,NEXT,DONE), octant sign tables,
//   default SCREEN_W/SCREEN_H constants.
//  Sub-module circle_engine: single-circle midpoint stepper (go/busy/last, pixel out,
//   clip); top holds slot shadow regs, sequencer FSM, output mux.
// TESTING
//  slot0 en, (80,60) r=0, others off -> exactly 8 plots at (80,60) colour slot0, done=1.
//  slot0 (80,60) r=1 -> 16 plot cycles, pixel set {(80,61),(81,60),(79,60),(80,59),(81,61)..}.
//  enable=3'b010, slot1 r=5 colour 3'b101 -> every plot uses slot1 centre/colour only.
//  slot0 (2,2) r=10 -> no plot with x>=160 or negative; total cycles as unclipped.
//  rst pulse mid-DRAW -> next cycle state IDLE, vga_plot=0, done=0; restart redraws fully.
//  MULTI_ARC_ARC_MASK_EN, mask 8'h0F, r=20 -> plots only octants 0..3 (y>=centre_y).

Source files
------------

// File: rtl/multi_arc_renderer_pkg.sv
// rtl/multi_arc_renderer_pkg.sv - shared state codes, octant tables and screen defaults for the arc renderer
package multi_arc_renderer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_INIT = 3'd2;
    localparam state_t ST_DRAW = 3'd3;
    localparam state_t ST_NEXT = 3'd4;
    localparam state_t ST_DONE = 3'd5;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    // Octant k: swap puts oy on the x axis; x_neg/y_neg negate the x/y offset.
    localparam logic [7:0] OCT_SWAP  = 8'hAA;
    localparam logic [7:0] OCT_X_NEG = 8'h3C;
    localparam logic [7:0] OCT_Y_NEG = 8'hF0;

endpackage

// File: rtl/multi_arc_renderer_circle_engine.sv
// rtl/multi_arc_renderer_circle_engine.sv - single-circle midpoint stepper, one octant pixel per cycle with clipping
module multi_arc_renderer_circle_engine
    import multi_arc_renderer_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go,
    input  logic [X_W-1:0] cx,
    input  logic [Y_W-1:0] cy,
    input  logic [X_W-1:0] r,
    output logic           busy,
    output logic           last,
    output logic [2:0]     oct,
    output logic [X_W-1:0] px,
    output logic [Y_W-1:0] py,
    output logic           clip
);

    localparam int CW = X_W + 2;
    localparam logic signed [CW-1:0] ONE   = CW'(1);
    localparam logic signed [CW-1:0] LIM_X = CW'(SCREEN_W);
    localparam logic signed [CW-1:0] LIM_Y = CW'(SCREEN_H);

    logic signed [CW-1:0] ox, oy, crit;
    logic signed [CW-1:0] ox_n, oy_n, crit_n;
    logic signed [CW-1:0] dx, dy, sx, sy, pxs, pys;
    logic signed [CW-1:0] r_s;

    assign r_s = $signed({2'b00, r});

    always_comb begin
        ox_n = ox + ONE;
        if (crit <= 0) begin
            oy_n   = oy;
            crit_n = crit + (ox_n <<< 1) + ONE;
        end else begin
            oy_n   = oy - ONE;
            crit_n = crit + ((ox_n - oy_n) <<< 1) + ONE;
        end
    end

    assign last = busy && (oct == 3'd7) && (oy_n < ox_n);

    always_comb begin
        dx  = OCT_SWAP[oct] ? oy : ox;
        dy  = OCT_SWAP[oct] ? ox : oy;
        sx  = OCT_X_NEG[oct] ? -dx : dx;
        sy  = OCT_Y_NEG[oct] ? -dy : dy;
        pxs = $signed({2'b00, cx}) + sx;
        pys = $signed({{(CW-Y_W){1'b0}}, cy}) + sy;
    end

    assign clip = pxs[CW-1] || pys[CW-1] || (pxs >= LIM_X) || (pys >= LIM_Y);
    assign px   = pxs[X_W-1:0];
    assign py   = pys[Y_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            oct  <= 3'd0;
            ox   <= '0;
            oy   <= '0;
            crit <= '0;
        end else if (go) begin
            busy <= 1'b1;
            oct  <= 3'd0;
            ox   <= '0;
            oy   <= r_s;
            crit <= ONE - r_s;
        end else if (busy) begin
            oct <= oct + 3'd1;
            if (oct == 3'd7) begin
                ox   <= ox_n;
                oy   <= oy_n;
                crit <= crit_n;
                if (oy_n < ox_n) busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_arc_renderer.sv
// rtl/multi_arc_renderer.sv - sequences up to N_CIRCLES midpoint circles onto the VGA plot port
// Optional octant masking (Reuleaux arcs) is built when MULTI_ARC_ARC_MASK_EN is defined.
module multi_arc_renderer
    import multi_arc_renderer_pkg::*;
#(
    parameter int N_CIRCLES = 3,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COL_W     = 3,
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int SCREEN_H  = DEF_SCREEN_H
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_CIRCLES-1:0]       enable,
    input  logic [N_CIRCLES*X_W-1:0]   centre_x,
    input  logic [N_CIRCLES*Y_W-1:0]   centre_y,
    input  logic [N_CIRCLES*X_W-1:0]   radius,
    input  logic [N_CIRCLES*COL_W-1:0] colour,
    input  logic [N_CIRCLES*8-1:0]     octant_mask,
    output logic                       done,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [COL_W-1:0]           vga_colour,
    output logic                       vga_plot
);

    localparam int SLOT_W = (N_CIRCLES > 1) ? $clog2(N_CIRCLES) : 1;

    state_t                     state;
    logic [SLOT_W-1:0]          slot;
    logic [N_CIRCLES-1:0]       en_q;
    logic [N_CIRCLES*X_W-1:0]   cx_q, r_q;
    logic [N_CIRCLES*Y_W-1:0]   cy_q;
    logic [N_CIRCLES*COL_W-1:0] col_q;
    logic [X_W-1:0]             hold_x;
    logic [Y_W-1:0]             hold_y;
    logic [COL_W-1:0]           hold_col;

    logic                       cur_en;
    logic [X_W-1:0]             cur_cx, cur_r;
    logic [Y_W-1:0]             cur_cy;
    logic [COL_W-1:0]           cur_col;
    logic [7:0]                 cur_mask;

    logic                       go, busy, last, clip, oct_en, drawing;
    logic [2:0]                 oct;
    logic [X_W-1:0]             px;
    logic [Y_W-1:0]             py;

`ifdef MULTI_ARC_ARC_MASK_EN
    logic [N_CIRCLES*8-1:0]     mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    mask_q <= '0;
        else if (state == ST_LOAD)  mask_q <= octant_mask;
    end
`else
    logic [N_CIRCLES*8-1:0]     mask_q;
    logic                       unused_mask;

    assign mask_q      = '1;
    assign unused_mask = ^octant_mask;
`endif

    always_comb begin
        cur_en   = 1'b0;
        cur_cx   = '0;
        cur_cy   = '0;
        cur_r    = '0;
        cur_col  = '0;
        cur_mask = '0;
        for (int i = 0; i < N_CIRCLES; i++) begin
            if (slot == SLOT_W'(i)) begin
                cur_en   = en_q[i];
                cur_cx   = cx_q[i*X_W +: X_W];
                cur_cy   = cy_q[i*Y_W +: Y_W];
                cur_r    = r_q[i*X_W +: X_W];
                cur_col  = col_q[i*COL_W +: COL_W];
                cur_mask = mask_q[i*8 +: 8];
            end
        end
    end

    assign go      = (state == ST_INIT) && cur_en;
    assign drawing = (state == ST_DRAW);
    assign oct_en  = cur_mask[oct];

    multi_arc_renderer_circle_engine #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_engine (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .cx   (cur_cx),
        .cy   (cur_cy),
        .r    (cur_r),
        .busy (busy),
        .last (last),
        .oct  (oct),
        .px   (px),
        .py   (py),
        .clip (clip)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            slot  <= '0;
            en_q  <= '0;
            cx_q  <= '0;
            cy_q  <= '0;
            r_q   <= '0;
            col_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_LOAD;
                ST_LOAD: begin
                    en_q  <= enable;
                    cx_q  <= centre_x;
                    cy_q  <= centre_y;
                    r_q   <= radius;
                    col_q <= colour;
                    slot  <= '0;
                    state <= ST_INIT;
                end
                ST_INIT: state <= cur_en ? ST_DRAW : ST_NEXT;
                ST_DRAW: if (last || !busy) state <= ST_NEXT;
                ST_NEXT: begin
                    if (slot == SLOT_W'(N_CIRCLES - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        slot  <= slot + SLOT_W'(1);
                        state <= ST_INIT;
                    end
                end
                ST_DONE: if (!start) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pixel bus keeps the last drawn value whenever no circle is being stepped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_x   <= '0;
            hold_y   <= '0;
            hold_col <= '0;
        end else if (drawing) begin
            hold_x   <= px;
            hold_y   <= py;
            hold_col <= cur_col;
        end
    end

    assign vga_x      = drawing ? px      : hold_x;
    assign vga_y      = drawing ? py      : hold_y;
    assign vga_colour = drawing ? cur_col : hold_col;
    assign vga_plot   = drawing && !clip && oct_en;
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_multi_arc_renderer.sv
// tb/tb_multi_arc_renderer.sv - table-driven and randomized checks of multi_arc_renderer against a pixel-list model
module tb_multi_arc_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  enable;
    logic [23:0] centre_x;
    logic [20:0] centre_y;
    logic [23:0] radius;
    logic [8:0]  colour;
    logic [23:0] octant_mask;
    logic        done;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    multi_arc_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .enable      (enable),
        .centre_x    (centre_x),
        .centre_y    (centre_y),
        .radius      (radius),
        .colour      (colour),
        .octant_mask (octant_mask),
        .done        (done),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  en;
        logic [23:0] cx;
        logic [20:0] cy;
        logic [23:0] r;
        logic [8:0]  col;
        logic [23:0] mask;
        int          exp_len;
        int          exp_plots;
    } vec_t;

    typedef struct {
        bit plot;
        int x;
        int y;
        int col;
    } pix_t;

    int   tests = 0;
    int   fails = 0;
    pix_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] en, input logic [23:0] cx, input logic [20:0] cy,
                                input logic [23:0] r, input logic [8:0] col, input logic [23:0] mask,
                                input int len, input int plots);
        vec_t v;
        v.en = en; v.cx = cx; v.cy = cy; v.r = r; v.col = col; v.mask = mask;
        v.exp_len = len; v.exp_plots = plots;
        return v;
    endfunction

    // One entry per cycle after start is taken: LOAD, then INIT/[pixels]/NEXT per slot.
    task automatic build_model(input vec_t v);
        pix_t p;
        int   cx, cy, r, col, x, y, d, dx, dy, ax, ay;
        bit   m;
        exp_q.delete();
        p = '{0, 0, 0, 0};
        exp_q.push_back(p);
        for (int s = 0; s < 3; s++) begin
            exp_q.push_back(p);
            if (v.en[s]) begin
                cx = int'(v.cx[s*8 +: 8]);
                cy = int'(v.cy[s*7 +: 7]);
                r  = int'(v.r[s*8 +: 8]);
                col = int'(v.col[s*3 +: 3]);
                x = 0; y = r; d = 1 - r;
                while (y >= x) begin
                    for (int k = 0; k < 8; k++) begin
                        case (k)
                            0: begin dx =  x; dy =  y; end
                            1: begin dx =  y; dy =  x; end
                            2: begin dx = -x; dy =  y; end
                            3: begin dx = -y; dy =  x; end
                            4: begin dx = -x; dy = -y; end
                            5: begin dx = -y; dy = -x; end
                            6: begin dx =  x; dy = -y; end
                            default: begin dx = y; dy = -x; end
                        endcase
                        ax = cx + dx;
                        ay = cy + dy;
`ifdef MULTI_ARC_ARC_MASK_EN
                        m = v.mask[s*8 + k];
`else
                        m = 1'b1;
`endif
                        exp_q.push_back('{(ax >= 0 && ax < 160 && ay >= 0 && ay < 120 && m), ax, ay, col});
                    end
                    x++;
                    if (d <= 0) d += 2 * x + 1;
                    else begin
                        y--;
                        d += 2 * (x - y) + 1;
                    end
                end
            end
            exp_q.push_back(p);
        end
    endtask

    task automatic apply(input vec_t v);
        enable      = v.en;
        centre_x    = v.cx;
        centre_y    = v.cy;
        radius      = v.r;
        colour      = v.col;
        octant_mask = v.mask;
    endtask

    task automatic run_frame(input vec_t v, input string name, input bit drop_early);
        int k = 0, bad = 0, plots = 0, stay = 0;
        bit got_done = 0;
        build_model(v);
        apply(v);
        start = 1'b1;
        for (int c = 0; c < exp_q.size() + 50 && !got_done; c++) begin
            @(negedge clk);
            if (done) got_done = 1;
            else begin
                if (k < exp_q.size()) begin
                    if (vga_plot !== exp_q[k].plot ||
                        (exp_q[k].plot && (int'(vga_x) != exp_q[k].x || int'(vga_y) != exp_q[k].y ||
                                           int'(vga_colour) != exp_q[k].col))) begin
                        if (bad == 0)
                            $display("%s first diff at cycle %0d: plot=%0b (%0d,%0d) c=%0d want plot=%0b (%0d,%0d) c=%0d",
                                     name, k, vga_plot, vga_x, vga_y, vga_colour,
                                     exp_q[k].plot, exp_q[k].x, exp_q[k].y, exp_q[k].col);
                        bad++;
                    end
                end else bad++;
                if (vga_plot) plots++;
                k++;
                if (k == 2) begin
                    enable = 3'($urandom); centre_x = 24'($urandom); centre_y = 21'($urandom);
                    radius = 24'($urandom); colour = 9'($urandom); octant_mask = 24'($urandom);
                end
                if (drop_early && k == 5) start = 1'b0;
            end
        end
        chk({name, "_done_seen"}, int'(got_done), 1);
        chk({name, "_len_model"}, k, exp_q.size());
        chk({name, "_seq_diffs"}, bad, 0);
        if (v.exp_len >= 0)   chk({name, "_len"}, k, v.exp_len);
        if (v.exp_plots >= 0) chk({name, "_plots"}, plots, v.exp_plots);
        if (drop_early) begin
            @(negedge clk);
            chk({name, "_idle_after_done"}, int'(done), 0);
        end else begin
            repeat (6) begin
                @(negedge clk);
                if (done && !vga_plot) stay++;
            end
            chk({name, "_done_held"}, stay, 6);
            start = 1'b0;
            @(negedge clk);
            chk({name, "_done_release"}, int'(done), 0);
            chk({name, "_plot_idle"}, int'(vga_plot), 0);
        end
    endtask

    vec_t tbl[4];
    vec_t v;

    initial begin
        rst = 1'b1; start = 1'b0;
        enable = '0; centre_x = '0; centre_y = '0; radius = '0; colour = '0; octant_mask = '0;
        #1;
        chk("reset_plot", int'(vga_plot), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_x", int'(vga_x), 0);
        chk("reset_y", int'(vga_y), 0);
        chk("reset_colour", int'(vga_colour), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_plot", int'(vga_plot), 0);

        tbl[0] = mk(3'b001, {8'd0, 8'd0, 8'd80}, {7'd0, 7'd0, 7'd60}, {8'd0, 8'd0, 8'd0},
                    {3'd0, 3'd0, 3'd6}, 24'hFFFFFF, 15, 8);
        tbl[1] = mk(3'b001, {8'd0, 8'd0, 8'd80}, {7'd0, 7'd0, 7'd60}, {8'd0, 8'd0, 8'd1},
                    {3'd0, 3'd0, 3'd3}, 24'hFFFFFF, 23, 16);
        tbl[2] = mk(3'b010, {8'd30, 8'd80, 8'd10}, {7'd30, 7'd60, 7'd10}, {8'd4, 8'd5, 8'd3},
                    {3'd2, 3'd5, 3'd1}, 24'hFFFFFF, 39, 32);
        tbl[3] = mk(3'b001, {8'd0, 8'd0, 8'd2}, {7'd0, 7'd0, 7'd2}, {8'd0, 8'd0, 8'd10},
                    {3'd0, 3'd0, 3'd7}, 24'hFFFFFF, 71, -1);
        for (int i = 0; i < 4; i++) run_frame(tbl[i], $sformatf("tbl%0d", i), 1'b0);

        for (int i = 0; i < 6; i++) begin
            v = mk(3'($urandom), 24'($urandom), 21'($urandom), 24'($urandom) & 24'h1F1F1F,
                   9'($urandom), 24'($urandom), -1, -1);
            run_frame(v, $sformatf("rnd%0d", i), i == 2);
        end

`ifdef MULTI_ARC_ARC_MASK_EN
        v = mk(3'b001, {8'd0, 8'd0, 8'd80}, {7'd0, 7'd0, 7'd60}, {8'd0, 8'd0, 8'd20},
               {3'd0, 3'd0, 3'd4}, 24'h00000F, -1, -1);
        run_frame(v, "mask0f", 1'b0);
`endif

        // Asynchronous reset in the middle of a circle, then a full redraw.
        v = mk(3'b001, {8'd0, 8'd0, 8'd80}, {7'd0, 7'd0, 7'd60}, {8'd0, 8'd0, 8'd20},
               {3'd0, 3'd0, 3'd2}, 24'hFFFFFF, -1, -1);
        apply(v);
        start = 1'b1;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_plot", int'(vga_plot), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_x", int'(vga_x), 0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_done", int'(done), 0);
        chk("postrst_plot", int'(vga_plot), 0);
        run_frame(v, "redraw", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
